// File: rtl/pipeline_exec_ctrl.sv
// Execution controller for the 5-stage pipeline: shared segment-register clock enable,
// debug command sequencing (run/step/pause/clear), HALT detection and cycle budget.
module pipeline_exec_ctrl #(
  parameter int CNT_W          = 32,
  parameter int MAX_RUN_CYCLES = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic             i_wb_halt,
  output logic             o_clk_en,
  output logic             o_pipe_reset,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic             o_timeout,
  output logic             o_cmd_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_PAUSE = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  // One bit wider than the counter so a budget above the counter range never matches.
  localparam logic [CNT_W:0] BUDGET     = (CNT_W + 1)'(MAX_RUN_CYCLES);
  localparam bit             HAS_BUDGET = (MAX_RUN_CYCLES > 0);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             timeout_q;
  logic             cmd_err_q;
  logic             pipe_reset_q;
  logic             accept_s;
  logic             budget_hit_s;

  assign o_cmd_ready   = (state_q != S_STEP);
  assign o_clk_en      = ((state_q == S_RUN) && !i_wb_halt) || (state_q == S_STEP);
  assign accept_s      = i_cmd_valid && o_cmd_ready;
  assign o_state       = state_q;
  assign o_cycle_count = cnt_q;
  assign o_timeout     = timeout_q;
  assign o_cmd_err     = cmd_err_q;
  assign o_pipe_reset  = pipe_reset_q;

  always_comb begin
    cnt_d = cnt_q;
    if (o_clk_en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign budget_hit_s = HAS_BUDGET && o_clk_en && ({1'b0, cnt_d} == BUDGET);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      timeout_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
      pipe_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      cmd_err_q    <= 1'b0;
      pipe_reset_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A HALT already in WB wins; any command offered alongside is dropped.
          if (i_wb_halt) begin
            state_q   <= S_HALTED;
            cmd_err_q <= accept_s;
          end else if (accept_s) begin
            case (i_cmd)
              CMD_RUN:  state_q <= S_RUN;
              CMD_STEP: state_q <= S_STEP;
              CMD_CLEAR: begin
                pipe_reset_q <= 1'b1;
                cnt_q        <= '0;
                timeout_q    <= 1'b0;
              end
              default:  cmd_err_q <= 1'b1;
            endcase
          end
        end
        S_RUN: begin
          cmd_err_q <= accept_s && (i_cmd != CMD_PAUSE);
          if (budget_hit_s) begin
            state_q   <= S_HALTED;
            timeout_q <= 1'b1;
          end else if (i_wb_halt) begin
            state_q <= S_HALTED;
          end else if (accept_s && (i_cmd == CMD_PAUSE)) begin
            state_q <= S_IDLE;
          end
        end
        S_STEP: begin
          if (budget_hit_s) begin
            state_q   <= S_HALTED;
            timeout_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_HALTED: begin
          if (accept_s) begin
            if (i_cmd == CMD_CLEAR) begin
              state_q      <= S_IDLE;
              pipe_reset_q <= 1'b1;
              cnt_q        <= '0;
              timeout_q    <= 1'b0;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Directed-vector bench for pipeline_exec_ctrl: table of per-cycle vectors plus
// hand-written sequences for counter saturation and the cycle budget.
module tb_pipeline_exec_ctrl;

  localparam logic [1:0] C_RUN   = 2'b00;
  localparam logic [1:0] C_STEP  = 2'b01;
  localparam logic [1:0] C_PAUSE = 2'b10;
  localparam logic [1:0] C_CLR   = 2'b11;
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_STEP  = 2'b10;
  localparam logic [1:0] S_HALT  = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   = 1'b1;
  logic       valid = 1'b0;
  logic [1:0] cmd   = 2'b00;
  logic       halt  = 1'b0;

  logic        ready_m, en_m, prs_m, to_m, err_m;
  logic [1:0]  state_m;
  logic [31:0] count_m;
  logic        ready_b, en_b, prs_b, to_b, err_b;
  logic [1:0]  state_b;
  logic [7:0]  count_b;
  logic        ready_s, en_s, prs_s, to_s, err_s;
  logic [1:0]  state_s;
  logic [2:0]  count_s;

  pipeline_exec_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(valid), .i_cmd(cmd), .o_cmd_ready(ready_m),
    .i_wb_halt(halt), .o_clk_en(en_m), .o_pipe_reset(prs_m), .o_state(state_m),
    .o_cycle_count(count_m), .o_timeout(to_m), .o_cmd_err(err_m)
  );

  pipeline_exec_ctrl #(.CNT_W(8), .MAX_RUN_CYCLES(5)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(valid), .i_cmd(cmd), .o_cmd_ready(ready_b),
    .i_wb_halt(halt), .o_clk_en(en_b), .o_pipe_reset(prs_b), .o_state(state_b),
    .o_cycle_count(count_b), .o_timeout(to_b), .o_cmd_err(err_b)
  );

  pipeline_exec_ctrl #(.CNT_W(3), .MAX_RUN_CYCLES(0)) dut_s (
    .i_clk(clk), .i_reset(rst), .i_cmd_valid(valid), .i_cmd(cmd), .o_cmd_ready(ready_s),
    .i_wb_halt(halt), .o_clk_en(en_s), .o_pipe_reset(prs_s), .o_state(state_s),
    .o_cycle_count(count_s), .o_timeout(to_s), .o_cmd_err(err_s)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic [1:0]  cmd;
    logic        h;
    logic [1:0]  st;
    logic        en;
    logic        rdy;
    logic [31:0] cnt;
    logic        to;
    logic        err;
    logic        prs;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add_row(input logic r, input logic v, input logic [1:0] c,
                                  input logic h, input logic [1:0] st, input logic en,
                                  input logic rdy, input logic [31:0] cnt, input logic to,
                                  input logic err, input logic prs);
    vec_t row;
    row.rst = r;  row.v = v;    row.cmd = c;   row.h = h;
    row.st  = st; row.en = en;  row.rdy = rdy; row.cnt = cnt;
    row.to  = to; row.err = err; row.prs = prs;
    tbl.push_back(row);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
  task automatic drive(input logic r, input logic v, input logic [1:0] c, input logic h);
    @(posedge clk);
    #1;
    rst = r; valid = v; cmd = c; halt = h;
    #2;
  endtask

  initial begin
    // T1/T2: reset, RUN, HALT after 10 enabled cycles, HALT held in WB
    add_row(0, 0, C_RUN,   0, S_IDLE, 0, 1, 0,  0, 0, 0);
    add_row(0, 1, C_RUN,   0, S_IDLE, 0, 1, 0,  0, 0, 0);
    for (int i = 0; i < 10; i++) add_row(0, 0, C_RUN, 0, S_RUN, 1, 1, 32'(i), 0, 0, 0);
    add_row(0, 0, C_RUN,   1, S_RUN,  0, 1, 10, 0, 0, 0);
    add_row(0, 0, C_RUN,   1, S_HALT, 0, 1, 10, 0, 0, 0);
    // T4: RUN in HALTED errors, CLEAR pulses pipe reset and zeroes count
    add_row(0, 1, C_RUN,   1, S_HALT, 0, 1, 10, 0, 0, 0);
    add_row(0, 0, C_RUN,   1, S_HALT, 0, 1, 10, 0, 1, 0);
    add_row(0, 1, C_CLR,   1, S_HALT, 0, 1, 10, 0, 0, 0);
    add_row(0, 0, C_RUN,   0, S_IDLE, 0, 1, 0,  0, 0, 1);
    add_row(0, 0, C_RUN,   0, S_IDLE, 0, 1, 0,  0, 0, 0);
    // T3: three single steps; valid held during STEP is not accepted
    for (int k = 0; k < 3; k++) begin
      add_row(0, 1, C_STEP, 0, S_IDLE, 0, 1, 32'(k), 0, 0, 0);
      add_row(0, 1, C_STEP, 0, S_STEP, 1, 0, 32'(k), 0, 0, 0);
    end
    // PAUSE in IDLE errors; HALT in IDLE beats an offered RUN
    add_row(0, 1, C_PAUSE, 0, S_IDLE, 0, 1, 3, 0, 0, 0);
    add_row(0, 0, C_RUN,   0, S_IDLE, 0, 1, 3, 0, 1, 0);
    add_row(0, 1, C_RUN,   1, S_IDLE, 0, 1, 3, 0, 0, 0);
    add_row(0, 0, C_RUN,   1, S_HALT, 0, 1, 3, 0, 1, 0);
    add_row(0, 1, C_CLR,   1, S_HALT, 0, 1, 3, 0, 0, 0);
    add_row(0, 0, C_RUN,   0, S_IDLE, 0, 1, 0, 0, 0, 1);
    // STEP in RUN errors, PAUSE returns to IDLE
    add_row(0, 1, C_RUN,   0, S_IDLE, 0, 1, 0, 0, 0, 0);
    add_row(0, 1, C_STEP,  0, S_RUN,  1, 1, 0, 0, 0, 0);
    add_row(0, 1, C_PAUSE, 0, S_RUN,  1, 1, 1, 0, 1, 0);
    add_row(0, 0, C_RUN,   0, S_IDLE, 0, 1, 2, 0, 0, 0);
    // T6: PAUSE together with HALT -> HALTED without error
    add_row(0, 1, C_RUN,   0, S_IDLE, 0, 1, 2, 0, 0, 0);
    add_row(0, 0, C_RUN,   0, S_RUN,  1, 1, 2, 0, 0, 0);
    add_row(0, 1, C_PAUSE, 1, S_RUN,  0, 1, 3, 0, 0, 0);
    add_row(0, 0, C_RUN,   1, S_HALT, 0, 1, 3, 0, 0, 0);
    add_row(0, 1, C_CLR,   1, S_HALT, 0, 1, 3, 0, 0, 0);
    add_row(0, 0, C_RUN,   0, S_IDLE, 0, 1, 0, 0, 0, 1);
    // Reset mid-RUN and mid-STEP
    add_row(0, 1, C_RUN,   0, S_IDLE, 0, 1, 0, 0, 0, 0);
    add_row(0, 0, C_RUN,   0, S_RUN,  1, 1, 0, 0, 0, 0);
    add_row(1, 0, C_RUN,   0, S_RUN,  1, 1, 1, 0, 0, 0);
    add_row(0, 0, C_RUN,   0, S_IDLE, 0, 1, 0, 0, 0, 0);
    add_row(0, 1, C_STEP,  0, S_IDLE, 0, 1, 0, 0, 0, 0);
    add_row(1, 0, C_RUN,   0, S_STEP, 1, 0, 0, 0, 0, 0);
    add_row(0, 0, C_RUN,   0, S_IDLE, 0, 1, 0, 0, 0, 0);
    // CLEAR from IDLE also pulses pipe reset
    add_row(0, 1, C_CLR,   0, S_IDLE, 0, 1, 0, 0, 0, 0);
    add_row(0, 0, C_RUN,   0, S_IDLE, 0, 1, 0, 0, 0, 1);
    add_row(0, 0, C_RUN,   0, S_IDLE, 0, 1, 0, 0, 0, 0);

    drive(1, 0, C_RUN, 0);
    drive(1, 0, C_RUN, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].cmd, tbl[i].h);
      chk($sformatf("row%0d_state", i), 32'(state_m), 32'(tbl[i].st));
      chk($sformatf("row%0d_clk_en", i), 32'(en_m), 32'(tbl[i].en));
      chk($sformatf("row%0d_ready", i), 32'(ready_m), 32'(tbl[i].rdy));
      chk($sformatf("row%0d_count", i), count_m, tbl[i].cnt);
      chk($sformatf("row%0d_timeout", i), 32'(to_m), 32'(tbl[i].to));
      chk($sformatf("row%0d_cmd_err", i), 32'(err_m), 32'(tbl[i].err));
      chk($sformatf("row%0d_pipe_reset", i), 32'(prs_m), 32'(tbl[i].prs));
    end

    // Counter saturation: 3-bit counter holds at 7 while the 32-bit one keeps counting
    drive(1, 0, C_RUN, 0);
    drive(0, 1, C_RUN, 0);
    for (int i = 0; i < 12; i++) drive(0, 0, C_RUN, 0);
    drive(0, 0, C_RUN, 0);
    chk("sat_count_wide", count_m, 32'd12);
    chk("sat_count_narrow", 32'(count_s), 32'd7);
    chk("sat_state_narrow", 32'(state_s), 32'(S_RUN));

    // T5: budget of 5 enabled cycles in RUN, no HALT
    drive(1, 0, C_RUN, 0);
    drive(0, 1, C_RUN, 0);
    begin
      int n_en;
      n_en = 0;
      for (int i = 0; i < 20; i++) begin
        drive(0, 0, C_RUN, 0);
        if (en_b) n_en++;
      end
      chk("budget_enabled_cycles", 32'(n_en), 32'd5);
    end
    chk("budget_state", 32'(state_b), 32'(S_HALT));
    chk("budget_timeout", 32'(to_b), 32'd1);
    chk("budget_count", 32'(count_b), 32'd5);
    chk("budget_clk_en", 32'(en_b), 32'd0);
    drive(0, 1, C_CLR, 0);
    chk("budget_timeout_sticky", 32'(to_b), 32'd1);
    drive(0, 0, C_RUN, 0);
    chk("budget_clr_pulse", 32'(prs_b), 32'd1);
    chk("budget_clr_timeout", 32'(to_b), 32'd0);
    chk("budget_clr_count", 32'(count_b), 32'd0);
    chk("budget_clr_state", 32'(state_b), 32'(S_IDLE));

    // Budget reached by STEP, with HALT arriving on the same edge
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, C_STEP, 0);
      chk($sformatf("bstep%0d_state", k), 32'(state_b), 32'(S_IDLE));
      chk($sformatf("bstep%0d_count", k), 32'(count_b), 32'(k));
      drive(0, 0, C_RUN, (k == 4) ? 1'b1 : 1'b0);
      chk($sformatf("bstep%0d_clk_en", k), 32'(en_b), 32'd1);
    end
    drive(0, 0, C_RUN, 1);
    chk("bstep_final_state", 32'(state_b), 32'(S_HALT));
    chk("bstep_final_timeout", 32'(to_b), 32'd1);
    chk("bstep_final_count", 32'(count_b), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
